multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle execution sequencer that drives the datapath from the single-cycle control decoder's signal bundle.
- Opcode and the decoded signals (regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop) come in; per-state datapath enables and the instruction/data memory handshakes go out.
- Sits between the control decoder, the register file/ALU latches and the memory ports.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100.

Parameters:
- TIMEOUT, 255, maximum cycles a memory request may wait for ack before trapping.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- regwrite, memread, memwrite, branch  in  1 each  decoded control from decoder
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a write
- dmem_ack  in  1  data access complete/read data valid
- ir_we  out  1  load IR
- pc_we  out  1  write PC
- pc_src  out  1  0: PC+4, 1: branch target
- ab_we  out  1  latch register-file outputs A/B
- aluout_we  out  1  latch ALU result
- mdr_we  out  1  latch memory read data
- rf_we  out  1  register-file write
- trap  out  1  sticky fault indicator
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State is a 3-bit register.
- Outputs are Moore-decoded from state, plus ack qualification where stated below.
- Reset (rst high at edge):
  - state to IDLE; retired = 0; wait counter = 0; trap = 0.
  - In IDLE all outputs are 0.
  - Reset mid-operation abandons any outstanding request; the request is deasserted the cycle after the reset edge.
- IDLE -> FETCH unconditionally next cycle.
- FETCH:
  - imem_req = 1 while in state.
  - On cycle with imem_ack = 1: ir_we = 1, pc_we = 1, pc_src = 0 (same cycle); next state DECODE.
  - Ack in the same cycle req rises is legal.
- DECODE:
  - ab_we = 1.
  - Opcode not in the supported set -> TRAP; else -> EXEC.
- EXEC:
  - aluout_we = 1.
  - If branch: pc_we = alu_zero, pc_src = 1; next FETCH; retire.
  - Else if memread | memwrite -> MEM.
  - Else -> WB.
- MEM:
  - dmem_req = 1; dmem_we = memwrite, held stable for the whole request.
  - On dmem_ack: mdr_we = memread.
  - After ack, a load goes to WB; a store goes to FETCH and retires.
- WB: rf_we = regwrite; next FETCH; retire.
- Retire means retired increments by 1 on the transition edge and wraps modulo 2^CNT_W.
- Timeout:
  - The wait counter clears on entering FETCH or MEM and increments each cycle without ack.
  - If the counter reaches TIMEOUT with no ack, go to TRAP; the request drops the next cycle.
- TRAP: trap = 1, all other outputs 0; exit only via rst.
- Ack inputs while the corresponding req is low are ignored.
- imem_req and dmem_req are never simultaneously high.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0 .. TRAP=6)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, reused by the control decoder.
- One natural sub-module: mem_wait_timer (counter with clear/enable/expired output), instantiated once and shared by FETCH and MEM.
- The FSM and output decode remain in multicycle_sequencer.

Test Plan:
- Reset then R-type (opcode 0, regwrite = 1), imem_ack on the first FETCH cycle -> state sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH; rf_we is 1 for exactly one cycle; retired = 1.
- lw (100011) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we = 0; mdr_we pulses on the ack cycle; WB rf_we = 1; retired increments.
- sw (101011) -> dmem_we = 1 throughout MEM; no WB state, no rf_we; back to FETCH with retired incremented.
- beq with alu_zero = 1 then alu_zero = 0 -> EXEC shows pc_we = 1, pc_src = 1 in the first case; pc_we = 0 in the second; both return to FETCH.
- Illegal opcode 111111 -> TRAP after DECODE, trap = 1 sticky; rst pulse returns to IDLE with trap = 0 and retired = 0.
- imem_ack withheld with TIMEOUT = 4 -> TRAP after 4 waiting cycles; imem_req = 0 thereafter; rst asserted mid-MEM drops dmem_req the following cycle.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding and the
// opcodes it accepts, also reused by the control decoder.
package multicycle_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_TRAP   = ST_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction and data memory request/acknowledge handshakes.
interface multicycle_sequencer_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );

endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts cycles a memory request has waited; expired fires on the last
// allowed waiting cycle so the sequencer can trap on the following edge.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle execution sequencer: walks each instruction through
// fetch/decode/exec/mem/writeback and drives the datapath latch enables.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              opcode,
    input  logic                    regwrite,
    input  logic                    memread,
    input  logic                    memwrite,
    input  logic                    branch,
    input  logic                    alu_zero,
    multicycle_sequencer_if.master  mem,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    pc_src,
    output logic                    ab_we,
    output logic                    aluout_we,
    output logic                    mdr_we,
    output logic                    rf_we,
    output logic                    trap,
    output logic [CNT_W-1:0]        retired
);

    state_t state;
    logic   mem_rd_q;
    logic   mem_wr_q;

    logic waiting;
    logic ack_in;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    // Acks are only looked at in the state that owns the matching request.
    assign waiting = (state == S_FETCH) || (state == S_MEM);
    assign ack_in  = (state == S_FETCH) ? mem.imem_ack : mem.dmem_ack;
    assign tmr_en  = waiting && !ack_in;
    assign tmr_clr = !waiting || ack_in;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            retired  <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (mem.imem_ack) begin
                        state <= S_DECODE;
                    end else if (tmr_expired) begin
                        state <= S_TRAP;
                    end
                end
                S_DECODE: state <= op_supported(opcode) ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    // Capture the access type so dmem_we cannot change mid-request.
                    mem_rd_q <= memread;
                    mem_wr_q <= memwrite;
                    if (branch) begin
                        state   <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end else if (memread || memwrite) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        if (mem_wr_q) begin
                            state   <= S_FETCH;
                            retired <= retired + CNT_W'(1);
                        end else begin
                            state <= S_WB;
                        end
                    end else if (tmr_expired) begin
                        state <= S_TRAP;
                    end
                end
                S_WB: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    logic imem_req_c;
    logic dmem_req_c;
    logic dmem_we_c;

    always_comb begin
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        ab_we      = 1'b0;
        aluout_we  = 1'b0;
        mdr_we     = 1'b0;
        rf_we      = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                ir_we      = mem.imem_ack;
                pc_we      = mem.imem_ack;
            end
            S_DECODE: ab_we = 1'b1;
            S_EXEC: begin
                aluout_we = 1'b1;
                if (branch) begin
                    pc_we  = alu_zero;
                    pc_src = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = mem_wr_q;
                mdr_we     = mem.dmem_ack && mem_rd_q;
            end
            S_WB:    rf_we = regwrite;
            S_TRAP:  trap  = 1'b1;
            default: ;
        endcase
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;

endmodule
